alu32_sequencer: RTL and testbench
==================================

// Module: alu32_sequencer
// PURPOSE
// - Runs 32-bit operations on the shared 16-bit combinational ALU by sequencing two or three ALU passes per operation.
// - Sits between the register/issue logic and the ALU. It drives FSEL/ABUS/BBUS/CIN and captures FOUT and the ALU flags.
// - Returns the 32-bit result and 32-bit Z/S/C/V flags using a REQ/READY/VALID handshake.
// PARAMETERS
// - W     16  ALU word width; operands and result are 2*W bits wide.
// - OPW   4   width of OP.
// PORTS
// - CLK      in   1    rising-edge clock
// - RST      in   1    asynchronous, active-high reset
// - REQ      in   1    operation request
// - OP       in   4    0 TSA, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 SHL, 8 SHR, 9 ASR; any other code runs as TSA
// - A, B     in   32   operands
// - READY    out  1    high only in IDLE
// - VALID    out  1    one-cycle completion strobe
// - RESULT   out  32   registered result
// - ZF,SF,CF,VF out 1 each  registered 32-bit flags
// - FSEL out 4, ABUS out 16, BBUS out 16, CIN out 1   ALU drive (ALU codes: TSA 0, INC 1, DEC 2, ADD 3, SUB 4, AND 5, OR 6, XOR 7, NOT 8, RLC C, RRC D)
// - FOUT in 16, Z/S/C/V in 1   ALU response; ALU SUB C = borrow
// BEHAVIOUR
// - Reset: state IDLE. READY=1. VALID=0. RESULT, flags and CIN = 0. FSEL=TSA, ABUS=BBUS=0.
// - Accept: REQ&&READY at an edge latches OP, A and B, then moves to P1. REQ while busy is ignored and is not queued.
// - States: IDLE -> P1 -> P2 -> [FIX] -> DONE -> IDLE.
//   - ALU drive is a combinational function of the state and the latched inputs.
//   - FOUT/C are captured at the edge that leaves each pass state.
// - Pass order:
//   - Low word first for TSA/ADD/SUB/logic/SHL.
//   - High word first for SHR/ASR.
// - ADD: P1 ADD lo, P2 ADD hi. If the low carry is 1, FIX runs INC on the captured high word; otherwise FIX is skipped.
// - SUB: P1 SUB lo, P2 SUB hi. If the low borrow is 1, FIX runs DEC on the captured high word.
// - SHL: P1 RLC lo with CIN=0. P2 RLC hi with CIN = P1 carry.
// - SHR: P1 RRC hi with CIN=0. P2 RRC lo with CIN = P1 carry.
// - ASR: P1 RRC hi with CIN=A[31]. P2 RRC lo with CIN = P1 carry.
// - TSA/logic/NOT: P1 lo, P2 hi, single ALU op each. CIN=0 for every non-shift pass.
// - Flags (computed by the sequencer, not copied from the ALU):
//   - ZF = RESULT==0. SF = RESULT[31].
//   - ADD: CF = hi carry | (FIX && pre-FIX hi==FFFF). VF = (A31==B31) && (R31!=A31).
//   - SUB: CF = hi borrow | (FIX && pre-FIX hi==0000). VF = (A31!=B31) && (R31!=A31).
//   - SHL: CF = A[31], VF = CF^R31.
//   - SHR: CF = A[0], VF = A[31].
//   - ASR: CF = A[0], VF = 0.
//   - All other ops: CF = VF = 0.
// - DONE: RESULT and flags are updated on entry. VALID=1 for exactly one cycle, then IDLE.
// - Latency from accept edge to VALID high: 3 cycles, or 4 with FIX. Back-to-back throughput: 1 op per 4 or 5 cycles.
// - RESULT and flags hold between operations.
// - RST mid-operation aborts immediately: no VALID, and all outputs return to reset values.
// CONFIGURATION
// - ALU32_SEQ_PERF_EN defined:
//   - Adds output PERF_CNT[15:0], the count of VALID strobes.
//   - PERF_CNT saturates at FFFF and is cleared by RST.
//   - Adds output FIX_CNT[15:0], the count of FIX passes, with the same saturation and reset rules.
// - Not defined: neither port nor counter exists, and behaviour is otherwise identical.
// TESTING
// - ADD 0000FFFF+00000001 -> RESULT 00010000, Z0 S0 C0 V0. FIX taken. VALID 4 cycles after accept.
// - ADD 7FFFFFFF+00000001 -> 80000000, S1 V1 C0. SUB 00000000-00000001 -> FFFFFFFF, S1 C1 V0.
// - SHL 80008000 -> 00010000, C1 V1. ASR 80000001 -> C0000000, S1 C1 V0. SHR 00000001 -> 0, Z1 C1.
// - XOR AAAA5555^5555AAAA -> FFFFFFFF, S1. VALID 3 cycles after accept. REQ held during busy is not accepted until READY.
// - RST asserted in P2 of ADD -> READY=1 and VALID=0 at once; RESULT=0. The next ADD 1+1 -> 00000002.
// - With ALU32_SEQ_PERF_EN: 3 ops with 1 FIX -> PERF_CNT=3, FIX_CNT=1. RST clears both to 0.

Source files
------------

// File: rtl/alu32_sequencer.sv
// alu32_sequencer: runs 32-bit operations as two or three passes through an
// external 16-bit combinational ALU, returning a registered 32-bit result and
// sequencer-computed Z/S/C/V flags over a req/ready/valid handshake.
// Optional build macro ALU32_SEQ_PERF_EN adds saturating perf_cnt (completed
// operations) and fix_cnt (carry/borrow fix-up passes) outputs.
module alu32_sequencer #(
  parameter int W   = 16,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [OPW-1:0] op,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic           ready,
  output logic           valid,
  output logic [2*W-1:0] result,
  output logic           zf,
  output logic           sf,
  output logic           cf,
  output logic           vf,
  output logic [3:0]     fsel,
  output logic [W-1:0]   abus,
  output logic [W-1:0]   bbus,
  output logic           cin,
  input  logic [W-1:0]   fout,
  input  logic           z,
  input  logic           s,
  input  logic           c,
  input  logic           v
`ifdef ALU32_SEQ_PERF_EN
  ,
  output logic [15:0]    perf_cnt,
  output logic [15:0]    fix_cnt
`endif
);

  // ALU function codes
  localparam logic [3:0] F_TSA = 4'h0;
  localparam logic [3:0] F_INC = 4'h1;
  localparam logic [3:0] F_DEC = 4'h2;
  localparam logic [3:0] F_ADD = 4'h3;
  localparam logic [3:0] F_SUB = 4'h4;
  localparam logic [3:0] F_AND = 4'h5;
  localparam logic [3:0] F_OR  = 4'h6;
  localparam logic [3:0] F_XOR = 4'h7;
  localparam logic [3:0] F_NOT = 4'h8;
  localparam logic [3:0] F_RLC = 4'hC;
  localparam logic [3:0] F_RRC = 4'hD;

  typedef enum logic [3:0] {
    K_TSA, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOT, K_SHL, K_SHR, K_ASR
  } kind_t;

  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_FIX, S_DONE} state_t;

  state_t         state;
  kind_t          kind_q;
  logic [2*W-1:0] a_q, b_q;
  logic [W-1:0]   p1_q, p2_q;     // ALU output captured leaving P1 / P2
  logic           c1_q, c2_q;     // ALU carry captured leaving P1 / P2

  logic           hi_first, uses_b, is_shift, need_fix;
  logic [3:0]     pass_fn;
  logic [2*W-1:0] fin_result;
  logic           fin_cf, fin_vf, hi_carry, hi_wrap;

  // The ALU's own Z/S/V describe a single 16-bit pass; 32-bit flags are
  // rebuilt here, so those inputs are intentionally left unconsumed.
  logic unused_alu_flags;
  assign unused_alu_flags = ^{z, s, v};

  function automatic kind_t decode_op(input logic [OPW-1:0] o);
    case (o)
      OPW'(1): return K_ADD;
      OPW'(2): return K_SUB;
      OPW'(3): return K_AND;
      OPW'(4): return K_OR;
      OPW'(5): return K_XOR;
      OPW'(6): return K_NOT;
      OPW'(7): return K_SHL;
      OPW'(8): return K_SHR;
      OPW'(9): return K_ASR;
      default: return K_TSA;  // unused codes behave as transfer
    endcase
  endfunction

  // Right shifts walk from the high word down so the carry chains MSB->LSB.
  assign hi_first = (kind_q == K_SHR) || (kind_q == K_ASR);
  assign is_shift = hi_first || (kind_q == K_SHL);
  assign uses_b   = (kind_q == K_ADD) || (kind_q == K_SUB) || (kind_q == K_AND) ||
                    (kind_q == K_OR)  || (kind_q == K_XOR);
  // A low-word carry/borrow is folded into the high word by one INC/DEC pass.
  assign need_fix = ((kind_q == K_ADD) || (kind_q == K_SUB)) && c1_q;

  // ALU drive: pure function of state and latched operands; idle drives TSA 0.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    fsel    = F_TSA;
    abus    = '0;
    bbus    = '0;
    cin     = 1'b0;
    pass_fn = F_TSA;
    case (kind_q)
      K_ADD:        pass_fn = F_ADD;
      K_SUB:        pass_fn = F_SUB;
      K_AND:        pass_fn = F_AND;
      K_OR:         pass_fn = F_OR;
      K_XOR:        pass_fn = F_XOR;
      K_NOT:        pass_fn = F_NOT;
      K_SHL:        pass_fn = F_RLC;
      K_SHR, K_ASR: pass_fn = F_RRC;
      default:      pass_fn = F_TSA;
    endcase
    case (state)
      S_P1: begin
        fsel = pass_fn;
        abus = hi_first ? a_q[2*W-1:W] : a_q[W-1:0];
        bbus = uses_b ? b_q[W-1:0] : '0;
        cin  = (kind_q == K_ASR) ? a_q[2*W-1] : 1'b0;
      end
      S_P2: begin
        fsel = pass_fn;
        abus = hi_first ? a_q[W-1:0] : a_q[2*W-1:W];
        bbus = uses_b ? b_q[2*W-1:W] : '0;
        cin  = is_shift ? c1_q : 1'b0;
      end
      S_FIX: begin
        fsel = (kind_q == K_SUB) ? F_DEC : F_INC;
        abus = p2_q;
      end
      default: ;
    endcase
  end

  // Final 32-bit result and carry/overflow, valid in the cycle that enters DONE.
  always_comb begin
    fin_result = {fout, p1_q};
    if (state == S_P2 && hi_first) fin_result = {p1_q, fout};
    hi_carry = (state == S_FIX) ? c2_q : c;
    hi_wrap  = (state == S_FIX) &&
               ((kind_q == K_ADD) ? (p2_q == {W{1'b1}}) : (p2_q == '0));
    fin_cf = 1'b0;
    fin_vf = 1'b0;
    case (kind_q)
      K_ADD: begin
        fin_cf = hi_carry | hi_wrap;
        fin_vf = (a_q[2*W-1] == b_q[2*W-1]) && (fin_result[2*W-1] != a_q[2*W-1]);
      end
      K_SUB: begin
        fin_cf = hi_carry | hi_wrap;
        fin_vf = (a_q[2*W-1] != b_q[2*W-1]) && (fin_result[2*W-1] != a_q[2*W-1]);
      end
      K_SHL: begin
        fin_cf = a_q[2*W-1];
        fin_vf = a_q[2*W-1] ^ fin_result[2*W-1];
      end
      K_SHR: begin
        fin_cf = a_q[0];
        fin_vf = a_q[2*W-1];
      end
      K_ASR: fin_cf = a_q[0];
      default: ;
    endcase
  end

  // Sequencer FSM with registered handshake, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      kind_q <= K_TSA;
      a_q    <= '0;
      b_q    <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      c1_q   <= 1'b0;
      c2_q   <= 1'b0;
      ready  <= 1'b1;
      valid  <= 1'b0;
      result <= '0;
      zf     <= 1'b0;
      sf     <= 1'b0;
      cf     <= 1'b0;
      vf     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          valid <= 1'b0;
          if (req) begin
            kind_q <= decode_op(op);
            a_q    <= a;
            b_q    <= b;
            ready  <= 1'b0;
            state  <= S_P1;
          end
        end
        S_P1: begin
          p1_q  <= fout;
          c1_q  <= c;
          state <= S_P2;
        end
        S_P2: begin
          p2_q <= fout;
          c2_q <= c;
          if (need_fix) begin
            state <= S_FIX;
          end else begin
            state  <= S_DONE;
            valid  <= 1'b1;
            result <= fin_result;
            zf     <= (fin_result == '0);
            sf     <= fin_result[2*W-1];
            cf     <= fin_cf;
            vf     <= fin_vf;
          end
        end
        S_FIX: begin
          state  <= S_DONE;
          valid  <= 1'b1;
          result <= fin_result;
          zf     <= (fin_result == '0);
          sf     <= fin_result[2*W-1];
          cf     <= fin_cf;
          vf     <= fin_vf;
        end
        S_DONE: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU32_SEQ_PERF_EN
  // Saturating counters of completion strobes and fix-up passes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt <= '0;
      fix_cnt  <= '0;
    end else begin
      if (valid && perf_cnt != 16'hFFFF) perf_cnt <= perf_cnt + 16'd1;
      if (state == S_FIX && fix_cnt != 16'hFFFF) fix_cnt <= fix_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu32_sequencer.sv
// Directed testbench for alu32_sequencer with a behavioural 16-bit ALU model.
module tb_alu32_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [3:0]  op  = '0;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic        ready, valid, zf, sf, cf, vf;
  logic [31:0] result;
  logic [3:0]  fsel;
  logic [15:0] abus, bbus, fout;
  logic        cin, z, s, c, v;
  logic [3:0]  flags;
`ifdef ALU32_SEQ_PERF_EN
  logic [15:0] perf_cnt, fix_cnt;
`endif

  int checks = 0;
  int errors = 0;

  assign flags = {zf, sf, cf, vf};

  alu32_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .ready(ready), .valid(valid), .result(result),
    .zf(zf), .sf(sf), .cf(cf), .vf(vf),
    .fsel(fsel), .abus(abus), .bbus(bbus), .cin(cin),
    .fout(fout), .z(z), .s(s), .c(c), .v(v)
`ifdef ALU32_SEQ_PERF_EN
    , .perf_cnt(perf_cnt), .fix_cnt(fix_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared 16-bit ALU (SUB carry = borrow).
  always_comb begin
    logic [16:0] t;
    t = '0;
    c = 1'b0;
    case (fsel)
      4'h0: t = {1'b0, abus};
      4'h1: t = {1'b0, abus} + 17'd1;
      4'h2: begin t = {1'b0, abus - 16'd1}; t[16] = (abus == 16'h0000); end
      4'h3: t = {1'b0, abus} + {1'b0, bbus} + {16'b0, cin};
      4'h4: begin t = {1'b0, abus - bbus}; t[16] = (abus < bbus); end
      4'h5: t = {1'b0, abus & bbus};
      4'h6: t = {1'b0, abus | bbus};
      4'h7: t = {1'b0, abus ^ bbus};
      4'h8: t = {1'b0, ~abus};
      4'hC: t = {abus[15], abus[14:0], cin};
      4'hD: t = {abus[0], cin, abus[15:1]};
      default: t = {1'b0, abus};
    endcase
    fout = t[15:0];
    c    = t[16];
    z    = (t[15:0] == 16'h0000);
    s    = t[15];
    v    = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency, result, flags and strobe width.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [31:0] er,
                        input logic [3:0] ef, input int elat);
    int lat;
    lat = 0;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, ready}, 32'd1);
    req = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, result, er);
    check({tag, "_flg"}, {28'b0, flags}, {28'b0, ef});
    @(negedge clk);
    check({tag, "_vld1"}, {30'b0, valid, ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:1] seen;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'b0, flags}, 32'd0);
    check("rst_drive", {fsel, abus, bbus[10:0], cin}, 32'd0);
    rst = 1'b0;

    //      tag      op    A             B             RESULT        ZSCV     lat
    run_op("add_fix", 4'd1, 32'h0000FFFF, 32'h00000001, 32'h00010000, 4'b0000, 4);
    run_op("add_ovf", 4'd1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 4);
    run_op("sub_brw", 4'd2, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0110, 4);
    run_op("shl",     4'd7, 32'h80008000, 32'h00000000, 32'h00010000, 4'b0011, 3);
    run_op("asr",     4'd9, 32'h80000001, 32'h00000000, 32'hC0000000, 4'b0110, 3);
    run_op("shr",     4'd8, 32'h00000001, 32'h00000000, 32'h00000000, 4'b1010, 3);
    run_op("shr_msb", 4'd8, 32'h80000000, 32'h00000000, 32'h40000000, 4'b0001, 3);
    run_op("add_cy",  4'd1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 4);
    run_op("sub_hi",  4'd2, 32'h00000000, 32'h00010000, 32'hFFFF0000, 4'b0110, 3);
    run_op("not",     4'd6, 32'h0F0F00FF, 32'h00000000, 32'hF0F0FF00, 4'b0100, 3);
    run_op("and",     4'd3, 32'hF0F0FFFF, 32'h0FF01234, 32'h00F01234, 4'b0000, 3);
    run_op("or_zero", 4'd4, 32'h00000000, 32'h00000000, 32'h00000000, 4'b1000, 3);
    run_op("tsa",     4'd0, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0100, 3);
    run_op("bad_op",  4'd15, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 4'b0000, 3);

    // REQ held through a busy XOR: second accept only once READY returns.
    @(negedge clk);
    req = 1'b1; op = 4'd5; a = 32'hAAAA5555; b = 32'h5555AAAA;
    seen = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      seen[k] = valid;
      if (k == 2) check("hold_busy_ready", {31'b0, ready}, 32'd0);
      if (k == 3) begin
        check("xor_res", result, 32'hFFFFFFFF);
        check("xor_flg", {28'b0, flags}, 32'h4);
      end
      if (k == 5) req = 1'b0;
    end
    check("hold_valid_pos", {24'b0, seen}, 32'h44);

    // Reset during P2 of an ADD aborts at once.
    @(negedge clk);
    req = 1'b1; op = 4'd1; a = 32'h0000FFFF; b = 32'h00000001;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("p2_drive", {fsel, abus, 12'b0}, {4'h3, 16'h0000, 12'b0});
    rst = 1'b1;
    #1;
    check("abort_hs", {30'b0, ready, valid}, 32'd2);
    check("abort_res", result, 32'd0);
    check("abort_drive", {fsel, abus, bbus[10:0], cin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("add_after", 4'd1, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 3);

`ifdef ALU32_SEQ_PERF_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("perf_clr0", {perf_cnt, fix_cnt}, 32'd0);
    run_op("pf_add", 4'd1, 32'h0000FFFF, 32'h00000001, 32'h00010000, 4'b0000, 4);
    run_op("pf_xor", 4'd5, 32'hAAAA5555, 32'h5555AAAA, 32'hFFFFFFFF, 4'b0100, 3);
    run_op("pf_shl", 4'd7, 32'h80008000, 32'h00000000, 32'h00010000, 4'b0011, 3);
    check("perf_cnt", {16'b0, perf_cnt}, 32'd3);
    check("fix_cnt", {16'b0, fix_cnt}, 32'd1);
    rst = 1'b1;
    #1;
    check("perf_clr", {perf_cnt, fix_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
